store_buffer: RTL

- Write-side counterpart of the load/writeback path.
- Committed stores from the memory stage enter an in-order FIFO and drain to the data bus one at a time.
- The block exposes a full-word store-to-load forwarding port: sb_fwd_en / sb_fwd_data / sb_fwd_addr.
- Writeback uses that port to override bus data on OP_LW when a newer, still-buffered store exists to the same address.

---
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Bundle of the store-buffer ports: store push side, data-bus request/response, forwarding port.
interface store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [3:0]    st_strobe;
  logic [2:0]    st_size;
  logic          st_full;
  logic          st_empty;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [3:0]    dreq_strobe;
  logic [DW-1:0] dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [AW-1:0] sb_fwd_addr;
  logic          sb_fwd_en;
  logic [DW-1:0] sb_fwd_data;

  modport master (
    output st_valid, st_addr, st_data, st_strobe, st_size, dresp_addr_ok, dresp_data_ok,
           sb_fwd_addr,
    input  st_full, st_empty, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           sb_fwd_en, sb_fwd_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_strobe, st_size, dresp_addr_ok, dresp_data_ok,
           sb_fwd_addr,
    output st_full, st_empty, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           sb_fwd_en, sb_fwd_data
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO draining to the data bus, with full-word store-to-load forwarding.
// Define STOREBUF_MERGE_EN to merge same-word pushes into the newest non-issuing entry.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  logic [AW-1:0] ent_addr   [DEPTH];
  logic [DW-1:0] ent_data   [DEPTH];
  logic [3:0]    ent_strobe [DEPTH];
  logic [2:0]    ent_size   [DEPTH];
  logic          ent_valid  [DEPTH];

  logic [PW-1:0] head, tail, newest;
  logic [PW:0]   count, count_after;
  state_e        state;
  logic          dreq_valid_q;
  logic          push, pop, merge;
  logic          fwd_hit;
  logic [DW-1:0] fwd_word;
  logic [PW-1:0] fwd_idx;
  logic          unused_fwd_lsb;

  assign bus.st_full    = (count == (PW+1)'(DEPTH));
  assign bus.st_empty   = (count == '0);
  assign bus.dreq_valid = dreq_valid_q;
  assign bus.dreq_addr  = ent_addr[head];
  assign bus.dreq_data  = ent_data[head];
  assign bus.dreq_strobe = ent_strobe[head];
  assign bus.dreq_size  = ent_size[head];
  assign bus.sb_fwd_en  = fwd_hit;
  assign bus.sb_fwd_data = fwd_word;
  assign unused_fwd_lsb = ^bus.sb_fwd_addr[1:0];

  assign newest = tail - PW'(1);
  assign pop    = bus.dresp_data_ok && (state != StIdle);

`ifdef STOREBUF_MERGE_EN
  logic [DW-1:0] merge_data;
  logic [3:0]    merge_strobe;
  logic [2:0]    merge_size;

  // The head is off-limits once its request is on the bus.
  assign merge = bus.st_valid && (count != '0) && !((newest == head) && (state != StIdle)) &&
                 (ent_addr[newest][AW-1:2] == bus.st_addr[AW-1:2]);

  always_comb begin
    merge_data = ent_data[newest];
    for (int b = 0; b < 4; b++) begin
      if (bus.st_strobe[b]) merge_data[8*b +: 8] = bus.st_data[8*b +: 8];
    end
    merge_strobe = ent_strobe[newest] | bus.st_strobe;
    merge_size   = (merge_strobe == 4'b1111) ? 3'b010 : ent_size[newest];
  end
`else
  assign merge = 1'b0;
`endif

  assign push        = bus.st_valid && !merge && !bus.st_full;
  assign count_after = count + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_valid[i] <= 1'b0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (push) begin
        ent_addr[tail]   <= bus.st_addr;
        ent_data[tail]   <= bus.st_data;
        ent_strobe[tail] <= bus.st_strobe;
        ent_size[tail]   <= bus.st_size;
        ent_valid[tail]  <= 1'b1;
        tail             <= tail + PW'(1);
      end
`ifdef STOREBUF_MERGE_EN
      if (merge) begin
        ent_data[newest]   <= merge_data;
        ent_strobe[newest] <= merge_strobe;
        ent_size[newest]   <= merge_size;
      end
`endif
      count <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      dreq_valid_q <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (count != '0) begin
            state        <= StAddr;
            dreq_valid_q <= 1'b1;
          end
        end
        StAddr, StData: begin
          if (bus.dresp_data_ok) begin
            state        <= (count_after != '0) ? StAddr : StIdle;
            dreq_valid_q <= (count_after != '0);
          end else if (state == StAddr && bus.dresp_addr_ok) begin
            state        <= StData;
            dreq_valid_q <= 1'b0;
          end
        end
        default: begin
          state        <= StIdle;
          dreq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Walk oldest to newest so the newest same-word entry decides; a partial store kills the hit.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_word = '0;
    fwd_idx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = head + PW'(i);
      if (ent_valid[fwd_idx] && (ent_addr[fwd_idx][AW-1:2] == bus.sb_fwd_addr[AW-1:2])) begin
        if (ent_strobe[fwd_idx] == 4'b1111) begin
          fwd_hit  = 1'b1;
          fwd_word = ent_data[fwd_idx];
        end else begin
          fwd_hit  = 1'b0;
          fwd_word = '0;
        end
      end
    end
  end
endmodule
